// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multicycle RISC-V core.
// Holds the main FSM state encodings, the opcode values it decodes,
// the ALUOp codes handed to alu_control and the datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating performance counter.
// Ports:
//   clk   - clock
//   clear - synchronous clear to zero (dominates inc)
//   inc   - add one this cycle unless already all-ones
//   count - current value
module perf_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V core.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// drives ALUOp and the datapath mux/enable controls, stalls on the cache
// handshake and keeps retired-instruction and stall-cycle counters.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   op                   - opcode from the instruction register
//   mem_ready            - cache finishes the current access this cycle
//   mem_req, adr_src     - memory request and address select
//   ir_write, pc_update  - IR load and unconditional PC write
//   branch               - conditional PC write (Zero-gated downstream)
//   reg_write, mem_write - register file / cache write enables
//   alu_src_a/b          - ALU operand selects
//   result_src           - result bus select
//   alu_op               - to alu_control
//   illegal_op           - pulse on an unsupported opcode in DECODE
//   state_o              - current state, for debug
//   retired_cnt          - completed instructions (saturating)
//   stall_cnt            - cycles waiting on mem_ready (saturating)
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_update,
    output logic             branch,
    output logic             reg_write,
    output logic             mem_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state_q, state_d;
    logic   retire;
    logic   stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;
        retire     = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                // PC+4 is written only on the completing cycle, so a stalled
                // fetch still advances the PC exactly once.
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Only memory states raise mem_req, so this covers exactly the
        // waiting cycles of FETCH, MEMREAD and MEMWRITE.
        stall = mem_req && !mem_ready;

        // Reset abandons any access in flight in the same cycle.
        if (reset) begin
            mem_req    = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_update  = 1'b0;
            branch     = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            alu_op     = 2'b00;
            illegal_op = 1'b0;
            retire     = 1'b0;
            stall      = 1'b0;
        end
    end

    assign state_o = state_q;

    perf_sat_counter #(
        .CNT_W(CNT_W)
    ) u_retired (
        .clk  (clk),
        .clear(reset),
        .inc  (retire),
        .count(retired_cnt)
    );

    perf_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall (
        .clk  (clk),
        .clear(reset),
        .inc  (stall),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed self-checking bench for multicycle_main_fsm.
// obs packs {state_o, mem_req, adr_src, ir_write, pc_update, branch,
// reg_write, mem_write, alu_src_a, alu_src_b, result_src, alu_op,
// illegal_op} so one compare checks a whole cycle's decode.
module tb_multicycle_main_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    // Expected obs per state (hand-packed).
    localparam logic [19:0] E_RST    = 20'h00000;
    localparam logic [19:0] E_FETCH  = 20'h0B050;
    localparam logic [19:0] E_FSTALL = 20'h08050;
    localparam logic [19:0] E_DEC    = 20'h100A0;
    localparam logic [19:0] E_DECBAD = 20'h100A1;
    localparam logic [19:0] E_MADR   = 20'h20120;
    localparam logic [19:0] E_MREAD  = 20'h3C000;
    localparam logic [19:0] E_MWB    = 20'h40408;
    localparam logic [19:0] E_MWRITE = 20'h5C200;
    localparam logic [19:0] E_EXR    = 20'h60104;
    localparam logic [19:0] E_EXI    = 20'h70124;
    localparam logic [19:0] E_ALUWB  = 20'h80400;
    localparam logic [19:0] E_JAL    = 20'h910C0;
    localparam logic [19:0] E_BEQ    = 20'hA0902;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic        mem_ready;
    logic        mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
    logic        illegal_op;
    logic [3:0]  state_o;
    logic [31:0] retired_cnt, stall_cnt;

    logic        mem_req_4, adr_src_4, ir_write_4, pc_update_4, branch_4;
    logic        reg_write_4, mem_write_4, illegal_op_4;
    logic [1:0]  alu_src_a_4, alu_src_b_4, result_src_4, alu_op_4;
    logic [3:0]  state_o_4;
    logic [3:0]  retired_cnt_4, stall_cnt_4;

    logic [19:0] obs;
    int          pass_n = 0;
    int          chk_n  = 0;

    assign obs = {state_o, mem_req, adr_src, ir_write, pc_update, branch, reg_write,
                  mem_write, alu_src_a, alu_src_b, result_src, alu_op, illegal_op};

    multicycle_main_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .pc_update(pc_update),
        .branch(branch), .reg_write(reg_write), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_op(alu_op), .illegal_op(illegal_op), .state_o(state_o),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    multicycle_main_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req_4), .adr_src(adr_src_4), .ir_write(ir_write_4),
        .pc_update(pc_update_4), .branch(branch_4), .reg_write(reg_write_4),
        .mem_write(mem_write_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
        .result_src(result_src_4), .alu_op(alu_op_4), .illegal_op(illegal_op_4),
        .state_o(state_o_4), .retired_cnt(retired_cnt_4), .stall_cnt(stall_cnt_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = LW; mem_ready = 1'b1;
        adv();
        chk_n++; if (obs !== E_RST) $display("FAIL reset_hold obs=%h exp=%h", obs, E_RST); else pass_n++;
        adv();
        chk_n++; if (obs !== E_RST) $display("FAIL reset_hold2 obs=%h exp=%h", obs, E_RST); else pass_n++;
        chk_n++; if (retired_cnt !== 32'd0) $display("FAIL reset_retired got=%0d exp=0", retired_cnt); else pass_n++;
        chk_n++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else pass_n++;
        reset = 1'b0;
        #1;
        chk_n++; if (obs !== E_FETCH) $display("FAIL reset_release obs=%h exp=%h", obs, E_FETCH); else pass_n++;
    endtask

    task automatic test_lw();
        op = LW; mem_ready = 1'b1;
        adv();
        chk_n++; if (obs !== E_DEC) $display("FAIL lw_decode obs=%h exp=%h", obs, E_DEC); else pass_n++;
        adv();
        chk_n++; if (obs !== E_MADR) $display("FAIL lw_memadr obs=%h exp=%h", obs, E_MADR); else pass_n++;
        adv();
        chk_n++; if (obs !== E_MREAD) $display("FAIL lw_memread obs=%h exp=%h", obs, E_MREAD); else pass_n++;
        adv();
        chk_n++; if (obs !== E_MWB) $display("FAIL lw_memwb obs=%h exp=%h", obs, E_MWB); else pass_n++;
        adv();
        chk_n++; if (obs !== E_FETCH) $display("FAIL lw_done obs=%h exp=%h", obs, E_FETCH); else pass_n++;
        chk_n++; if (retired_cnt !== 32'd1) $display("FAIL lw_retired got=%0d exp=1", retired_cnt); else pass_n++;
    endtask

    task automatic test_rtype();
        op = RT;
        adv();
        chk_n++; if (obs !== E_DEC) $display("FAIL r_decode obs=%h exp=%h", obs, E_DEC); else pass_n++;
        adv();
        chk_n++; if (obs !== E_EXR) $display("FAIL r_exec obs=%h exp=%h", obs, E_EXR); else pass_n++;
        adv();
        chk_n++; if (obs !== E_ALUWB) $display("FAIL r_aluwb obs=%h exp=%h", obs, E_ALUWB); else pass_n++;
        adv();
        chk_n++; if (obs !== E_FETCH) $display("FAIL r_done obs=%h exp=%h", obs, E_FETCH); else pass_n++;
        chk_n++; if (retired_cnt !== 32'd2) $display("FAIL r_retired got=%0d exp=2", retired_cnt); else pass_n++;
        chk_n++; if (stall_cnt !== 32'd0) $display("FAIL r_stall got=%0d exp=0", stall_cnt); else pass_n++;
    endtask

    task automatic test_beq_fetch_stall();
        op = BQ; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_n++;
            if (obs !== E_FSTALL) $display("FAIL beq_stall%0d obs=%h exp=%h", i, obs, E_FSTALL);
            else pass_n++;
            adv();
        end
        mem_ready = 1'b1;
        #1;
        chk_n++; if (obs !== E_FETCH) $display("FAIL beq_fetch_go obs=%h exp=%h", obs, E_FETCH); else pass_n++;
        adv();
        chk_n++; if (obs !== E_DEC) $display("FAIL beq_decode obs=%h exp=%h", obs, E_DEC); else pass_n++;
        chk_n++; if (stall_cnt !== 32'd3) $display("FAIL beq_stall_cnt got=%0d exp=3", stall_cnt); else pass_n++;
        adv();
        chk_n++; if (obs !== E_BEQ) $display("FAIL beq_exec obs=%h exp=%h", obs, E_BEQ); else pass_n++;
        adv();
        chk_n++; if (obs !== E_FETCH) $display("FAIL beq_done obs=%h exp=%h", obs, E_FETCH); else pass_n++;
        chk_n++; if (retired_cnt !== 32'd3) $display("FAIL beq_retired got=%0d exp=3", retired_cnt); else pass_n++;
    endtask

    task automatic test_sw_write_stall();
        op = SW; mem_ready = 1'b1;
        adv();
        chk_n++; if (obs !== E_DEC) $display("FAIL sw_decode obs=%h exp=%h", obs, E_DEC); else pass_n++;
        adv();
        chk_n++; if (obs !== E_MADR) $display("FAIL sw_memadr obs=%h exp=%h", obs, E_MADR); else pass_n++;
        adv();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            #1;
            chk_n++;
            if (obs !== E_MWRITE) $display("FAIL sw_memwrite%0d obs=%h exp=%h", i, obs, E_MWRITE);
            else pass_n++;
            adv();
        end
        chk_n++; if (obs !== E_FETCH) $display("FAIL sw_done obs=%h exp=%h", obs, E_FETCH); else pass_n++;
        chk_n++; if (retired_cnt !== 32'd4) $display("FAIL sw_retired got=%0d exp=4", retired_cnt); else pass_n++;
        chk_n++; if (stall_cnt !== 32'd5) $display("FAIL sw_stall_cnt got=%0d exp=5", stall_cnt); else pass_n++;
    endtask

    task automatic test_itype_jal();
        op = IT;
        adv();
        adv();
        chk_n++; if (obs !== E_EXI) $display("FAIL i_exec obs=%h exp=%h", obs, E_EXI); else pass_n++;
        adv();
        chk_n++; if (obs !== E_ALUWB) $display("FAIL i_aluwb obs=%h exp=%h", obs, E_ALUWB); else pass_n++;
        adv();
        op = JL;
        #1;
        chk_n++; if (obs !== E_FETCH) $display("FAIL jal_fetch obs=%h exp=%h", obs, E_FETCH); else pass_n++;
        adv();
        adv();
        chk_n++; if (obs !== E_JAL) $display("FAIL jal_exec obs=%h exp=%h", obs, E_JAL); else pass_n++;
        adv();
        chk_n++; if (obs !== E_ALUWB) $display("FAIL jal_aluwb obs=%h exp=%h", obs, E_ALUWB); else pass_n++;
        adv();
        chk_n++; if (retired_cnt !== 32'd6) $display("FAIL jal_retired got=%0d exp=6", retired_cnt); else pass_n++;
    endtask

    task automatic test_illegal();
        op = BAD;
        adv();
        chk_n++; if (obs !== E_DECBAD) $display("FAIL ill_decode obs=%h exp=%h", obs, E_DECBAD); else pass_n++;
        adv();
        chk_n++; if (obs !== E_FETCH) $display("FAIL ill_next obs=%h exp=%h", obs, E_FETCH); else pass_n++;
        chk_n++; if (retired_cnt !== 32'd6) $display("FAIL ill_retired got=%0d exp=6", retired_cnt); else pass_n++;
    endtask

    task automatic test_reset_midstall();
        op = LW; mem_ready = 1'b1;
        adv();
        adv();
        adv();
        mem_ready = 1'b0;
        #1;
        chk_n++; if (obs !== E_MREAD) $display("FAIL mid_memread obs=%h exp=%h", obs, E_MREAD); else pass_n++;
        reset = 1'b1;
        #1;
        chk_n++; if (obs !== 20'h30000) $display("FAIL mid_rst_drop obs=%h exp=30000", obs); else pass_n++;
        adv();
        chk_n++; if (obs !== E_RST) $display("FAIL mid_rst_state obs=%h exp=%h", obs, E_RST); else pass_n++;
        chk_n++; if (retired_cnt !== 32'd0) $display("FAIL mid_rst_retired got=%0d exp=0", retired_cnt); else pass_n++;
        chk_n++; if (stall_cnt !== 32'd0) $display("FAIL mid_rst_stall got=%0d exp=0", stall_cnt); else pass_n++;
        reset = 1'b0; mem_ready = 1'b1;
        #1;
        chk_n++; if (obs !== E_FETCH) $display("FAIL mid_release obs=%h exp=%h", obs, E_FETCH); else pass_n++;
    endtask

    task automatic test_back_to_back();
        op = RT; mem_ready = 1'b1;
        for (int i = 0; i < 15; i++) repeat (4) adv();
        chk_n++; if (retired_cnt_4 !== 4'd15) $display("FAIL sat_at15 got=%0d exp=15", retired_cnt_4); else pass_n++;
        for (int i = 0; i < 2; i++) repeat (4) adv();
        chk_n++; if (retired_cnt_4 !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", retired_cnt_4); else pass_n++;
        chk_n++; if (retired_cnt !== 32'd17) $display("FAIL b2b_retired got=%0d exp=17", retired_cnt); else pass_n++;
        chk_n++; if (stall_cnt_4 !== 4'd0) $display("FAIL b2b_stall4 got=%0d exp=0", stall_cnt_4); else pass_n++;
        chk_n++; if (obs !== E_FETCH) $display("FAIL b2b_state obs=%h exp=%h", obs, E_FETCH); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq_fetch_stall();
        test_sw_write_stall();
        test_itype_jal();
        test_illegal();
        test_reset_midstall();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control FSM for the multicycle RISC-V core, directly upstream of alu_control.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives ALUOp (consumed by alu_control together with op5/funct3/funct7) and all datapath mux and enable controls.
- Stalls on the cache handshake (mem_req/mem_ready); keeps retired-instruction and stall counters for the cache study.

Parameters:
- CNT_W, 32, width of the retired_cnt and stall_cnt counters.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- op  in  7  opcode from the instruction register; stable from DECODE onward
- mem_ready  in  1  cache completes the current access this cycle
- mem_req  out  1  memory access requested (FETCH, MEMREAD, MEMWRITE)
- adr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  instruction register load enable
- pc_update  out  1  unconditional PC write
- branch  out  1  conditional PC write (gated by Zero outside this block)
- reg_write  out  1  register file write enable
- mem_write  out  1  data write strobe to cache
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 data
- alu_src_b  out  2  00 rs2 data, 01 immediate, 10 constant 4
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_op  out  2  to alu_control: 00 add, 01 sub/compare, 10 funct-decoded
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state_o  out  4  current state encoding, for debug
- retired_cnt  out  CNT_W  count of completed instructions
- stall_cnt  out  CNT_W  count of cycles spent waiting on mem_ready

Behaviour:
- Reset: state loads FETCH and both counters load 0 at the edge.
  - While reset is high, every output except state_o is forced to 0.
- Outputs are a decode of the state register; ir_write and pc_update in FETCH are additionally qualified by mem_ready.
- Any output not listed for a state is 0.
- FETCH (0): mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_update = mem_ready.
  - mem_ready -> DECODE, else stay. The PC increments exactly once per fetch, however long the stall.
- DECODE (1): alu_src_a=01, alu_src_b=01, alu_op=00.
  - op 0000011 or 0100011 -> MEMADR
  - op 0110011 -> EXECUTER
  - op 0010011 -> EXECUTEI
  - op 1101111 -> JAL
  - op 1100011 -> BEQ
  - any other op -> FETCH with illegal_op=1 for this cycle; retired_cnt unchanged.
- MEMADR (2): alu_src_a=10, alu_src_b=01, alu_op=00. op 0000011 -> MEMREAD, else MEMWRITE.
- MEMREAD (3): mem_req=1, adr_src=1, result_src=00. mem_ready -> MEMWB.
- MEMWB (4): result_src=01, reg_write=1 -> FETCH.
- MEMWRITE (5): mem_req=1, mem_write=1, adr_src=1, result_src=00.
  - mem_write is held for the whole stall.
  - mem_ready -> FETCH.
- EXECUTER (6): alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECUTEI (7): alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB (8): result_src=00, reg_write=1 -> FETCH.
- JAL (9): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
- BEQ (10): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 -> FETCH.
- Unused encodings 11-15 -> FETCH on the next edge, all outputs 0.
- Instruction latency with no stalls:
  - lw 5 cycles
  - sw, R-type, I-type, jal 4 cycles
  - beq 3 cycles
- retired_cnt increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It does not increment on an illegal_op exit.
- stall_cnt increments on each cycle in FETCH, MEMREAD or MEMWRITE with mem_req=1 and mem_ready=0.
- Both counters saturate at all-ones and do not wrap.
- mem_ready outside a memory state is ignored.
- Reset mid-stall: mem_req drops in the same cycle reset is sampled high, and the access is abandoned.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encodings FETCH..BEQ
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - mux-select constants for alu_src_a, alu_src_b and result_src
- One sub-module, perf_sat_counter (CNT_W, synchronous clear, increment enable, saturation), instantiated twice.

Test Plan:
- Reset for 2 cycles, then release with mem_ready=1 -> during reset all outputs 0; first cycle after release state_o=0, mem_req=1, ir_write=1, pc_update=1.
- lw (op=0000011), mem_ready always 1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4, result_src=01 there; retired_cnt=1 after 5 cycles.
- R-type (op=0110011) -> alu_op=10 with alu_src_a=10, alu_src_b=00 in state 6; feed alu_op into alu_control with funct3=000 and {op5,funct7}=11 -> ALUControl=001 (subtract).
- beq with mem_ready held 0 for 3 FETCH cycles -> state stays 0, pc_update=0 for 3 cycles then 1 once; stall_cnt=3; in BEQ alu_op=01, branch=1.
- sw with mem_ready=0 for 2 cycles in MEMWRITE -> mem_write=1 for 3 consecutive cycles, then FETCH; retired_cnt +1, stall_cnt +2.
- op=1111111 -> illegal_op pulses for 1 cycle in DECODE, next state FETCH, retired_cnt unchanged.
- With CNT_W=4, 17 back-to-back R-type instructions -> retired_cnt stays 15 at saturation.
